// File: rtl/enigma_keyer.sv
// enigma_keyer: sequences Enigma machine button presses from NEXT/PLUG/ENCRYPT commands.
// Optional macro ENIGMA_KEYER_STATS_EN adds a 16-bit count of good ENCRYPT transfers (enc_count).
module enigma_keyer #(
  parameter int SETUP_CYCLES   = 1,
  parameter int PRESS_CYCLES   = 1,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_a,
  input  logic [4:0]  cmd_b,
  output logic [3:0]  btns,
  output logic [17:0] switches,
  input  logic [4:0]  ledr_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_letter,
  output logic        rsp_err
`ifdef ENIGMA_KEYER_STATS_EN
  ,
  output logic [15:0] enc_count
`endif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] PRESS   = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] SAMPLE  = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;
  localparam logic [1:0] OP_PLUG = 2'b01;
  localparam logic [1:0] OP_ENC  = 2'b10;
  localparam logic [3:0] SC = 4'(SETUP_CYCLES);
  localparam logic [3:0] PC = 4'(PRESS_CYCLES);
  localparam logic [3:0] RC = 4'(RELEASE_CYCLES);
  logic [2:0]  state, nxt;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic [16:0] sw;
  logic        mach_rst, accept, bad;
  assign cmd_ready = state == IDLE && !mach_rst;
  assign accept    = cmd_valid && cmd_ready;
  assign bad       = cmd_a > 5'd25 || (cmd_op == OP_PLUG && cmd_b > 5'd25) || cmd_op == 2'b11;
  assign rsp_valid = state == RESP;
  assign switches  = {mach_rst, sw};
  // Next state: bad ENCRYPT goes straight to RESP, other bad commands are swallowed in IDLE
  always_comb begin
    case (state)
      IDLE:    nxt = !accept ? IDLE : !bad ? SETUP : cmd_op == OP_ENC ? RESP : IDLE;
      SETUP:   nxt = cnt == SC ? PRESS : SETUP;
      PRESS:   nxt = cnt == PC ? RELEASE : PRESS;
      RELEASE: nxt = cnt != RC ? RELEASE : op == OP_ENC ? SAMPLE : IDLE;
      SAMPLE:  nxt = RESP;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  // State, per-state counter (restarts at 1 on entry, saturates) and machine-reset pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mach_rst <= 1'b1;
    end else begin
      state    <= nxt;
      cnt      <= nxt != state ? 4'd1 : cnt == 4'd15 ? cnt : cnt + 4'd1;
      mach_rst <= 1'b0;
    end
  end
  // Command capture; switches only move on the edge that enters SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= 2'b00;
      sw <= 17'd0;
    end else if (accept) begin
      op <= cmd_op;
      if (!bad && cmd_op == OP_PLUG) sw[9:0] <= {cmd_b, cmd_a};
      else if (!bad && cmd_op == OP_ENC) sw[4:0] <= cmd_a;
    end
  end
  // Buttons registered from next state so at most one is ever low and never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btns <= 4'hf;
    else btns <= nxt != PRESS ? 4'hf : op == OP_PLUG ? 4'b0111 : 4'b1110;
  end
  // Response capture: machine lamp letter in SAMPLE, or error for a rejected ENCRYPT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_letter <= 5'd0;
      rsp_err    <= 1'b0;
    end else if (state == SAMPLE) begin
      rsp_letter <= ledr_in;
      rsp_err    <= ledr_in > 5'd25;
    end else if (accept && bad && cmd_op == OP_ENC) begin
      rsp_letter <= 5'd0;
      rsp_err    <= 1'b1;
    end
  end
`ifdef ENIGMA_KEYER_STATS_EN
  // Count successful ENCRYPT results handed to the consumer; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) enc_count <= 16'd0;
    else if (state == RESP && rsp_ready && !rsp_err) enc_count <= enc_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_enigma_keyer.sv
// tb_enigma_keyer: randomized and directed checks of enigma_keyer against a command-level model.
module tb_enigma_keyer;
  localparam int S = 1;
  localparam int P = 1;
  localparam int R = 2;
  logic        clk = 0, rst_n = 0, cmd_valid = 0, rsp_ready = 0;
  logic [1:0]  cmd_op = 0;
  logic [4:0]  cmd_a = 0, cmd_b = 0, ledr_in = 0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [3:0]  btns;
  logic [17:0] switches;
  logic [4:0]  rsp_letter;
  logic [16:0] sw_m = 0;
  int          checks = 0, passed = 0, pulses = 0;
`ifdef ENIGMA_KEYER_STATS_EN
  logic [15:0] enc_count;
  int          good = 0;
`endif

  always #5 clk = ~clk;

  enigma_keyer #(.SETUP_CYCLES(S), .PRESS_CYCLES(P), .RELEASE_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .btns(btns), .switches(switches),
    .ledr_in(ledr_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_letter(rsp_letter), .rsp_err(rsp_err)
`ifdef ENIGMA_KEYER_STATS_EN
    , .enc_count(enc_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    else passed++;
  endtask

  // Issue one command and follow it cycle by cycle against the command-level model
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] l);
    bit bad, enc;
    logic [3:0] mask, eb;
    logic [4:0] el;
    logic ee;
    int lat, last;
    bad  = a > 25 || (op == 2'd1 && b > 25) || op == 2'd3;
    enc  = op == 2'd2;
    mask = op == 2'd1 ? 4'b0111 : 4'b1110;
    el   = bad ? 5'd0 : l;
    ee   = bad || l > 25;
    lat  = bad ? 0 : S + P + R + 1;
    last = enc ? lat + 3 : (bad ? 0 : S + P + R);
    wait_ready();
    ledr_in = l; cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1;
    step();
    cmd_valid = 0;
    if (!bad && op == 2'd1) sw_m[9:0] = {b, a};
    else if (!bad && enc) sw_m[4:0] = a;
    for (int j = 0; j <= last; j++) begin
      eb = (!bad && j >= S && j < S + P) ? mask : 4'hf;
      if (btns == mask && mask == 4'b1110) pulses++;
      checks++;
      if (btns !== eb) $display("FAIL btns op=%0d j=%0d: got %b required %b", op, j, btns, eb);
      else passed++;
      checks++;
      if (switches !== {1'b0, sw_m}) $display("FAIL switches op=%0d j=%0d: got %h required %h", op, j, switches, {1'b0, sw_m});
      else passed++;
      checks++;
      if (cmd_ready !== (!enc && j == last)) $display("FAIL cmd_ready op=%0d j=%0d: got %b required %b", op, j, cmd_ready, !enc && j == last);
      else passed++;
      checks++;
      if (rsp_valid !== (enc && j >= lat)) $display("FAIL rsp_valid op=%0d j=%0d: got %b required %b", op, j, rsp_valid, enc && j >= lat);
      else passed++;
      if (enc && j >= lat) begin
        checks++;
        if ({rsp_letter, rsp_err} !== {el, ee}) $display("FAIL rsp j=%0d: got letter=%0d err=%b required letter=%0d err=%b", j, rsp_letter, rsp_err, el, ee);
        else passed++;
        ledr_in = ~l;
      end
      if (j < last) step();
    end
    if (enc) begin
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rsp_transfer: got valid=%b ready=%b required valid=0 ready=1", rsp_valid, cmd_ready);
      else passed++;
`ifdef ENIGMA_KEYER_STATS_EN
      if (!ee) good++;
      checks++;
      if (enc_count !== 16'(good)) $display("FAIL enc_count: got %0d required %0d", enc_count, good);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    checks++;
    if ({switches, btns, rsp_valid, rsp_letter, rsp_err, cmd_ready} !== {18'h20000, 4'hf, 1'b0, 5'd0, 1'b0, 1'b0})
      $display("FAIL reset_vals: got sw=%h btns=%b valid=%b letter=%0d err=%b ready=%b required sw=20000 btns=1111 others 0",
               switches, btns, rsp_valid, rsp_letter, rsp_err, cmd_ready);
    else passed++;
    rst_n = 1;
    #1;
    checks++;
    if (switches[17] !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL reset_release: got sw17=%b ready=%b required sw17=1 ready=0", switches[17], cmd_ready);
    else passed++;
    step();
    checks++;
    if (switches[17] !== 1'b0 || cmd_ready !== 1'b1 || btns !== 4'hf) $display("FAIL reset_after_edge: got sw17=%b ready=%b btns=%b required 0 1 1111", switches[17], cmd_ready, btns);
    else passed++;
  endtask

  task automatic test_next();
    pulses = 0;
    for (int i = 0; i < 7; i++) do_cmd(2'd0, 5'($urandom_range(0, 25)), 5'($urandom_range(0, 31)), 5'd0);
    checks++;
    if (pulses !== 7) $display("FAIL next_pulses: got %0d required 7", pulses);
    else passed++;
  endtask

  task automatic test_plug();
    do_cmd(2'd1, 5'd0, 5'd1, 5'd0);
    do_cmd(2'd1, 5'd25, 5'd12, 5'd0);
    do_cmd(2'd0, 5'd3, 5'd0, 5'd0);
  endtask

  task automatic test_encrypt();
    do_cmd(2'd2, 5'd0, 5'd0, 5'd18);
    do_cmd(2'd2, 5'd26, 5'd0, 5'd4);
    do_cmd(2'd2, 5'd7, 5'd0, 5'd30);
    do_cmd(2'd2, 5'd25, 5'd31, 5'd25);
  endtask

  task automatic test_invalid();
    do_cmd(2'd3, 5'd1, 5'd2, 5'd0);
    do_cmd(2'd0, 5'd27, 5'd2, 5'd0);
    do_cmd(2'd1, 5'd4, 5'd29, 5'd0);
    do_cmd(2'd1, 5'd31, 5'd4, 5'd0);
  endtask

  task automatic test_reset_mid_press();
    wait_ready();
    ledr_in = 5'd9; cmd_op = 2'd2; cmd_a = 5'd5; cmd_b = 5'd0; cmd_valid = 1;
    step();
    cmd_valid = 0;
    step();
    checks++;
    if (btns !== 4'b1110) $display("FAIL mid_press_low: got %b required 1110", btns);
    else passed++;
    rst_n = 0;
    #1;
    checks++;
    if (btns !== 4'hf || rsp_valid !== 1'b0 || switches !== 18'h20000) $display("FAIL mid_press_reset: got btns=%b valid=%b sw=%h required 1111 0 20000", btns, rsp_valid, switches);
    else passed++;
    sw_m = 0;
`ifdef ENIGMA_KEYER_STATS_EN
    good = 0;
    checks++;
    if (enc_count !== 16'd0) $display("FAIL stats_reset: got %0d required 0", enc_count);
    else passed++;
`endif
    step();
    rst_n = 1;
    step();
    step();
    do_cmd(2'd2, 5'd11, 5'd0, 5'd2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      do_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 27)), 5'($urandom_range(0, 27)), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    test_reset();
    test_next();
    test_plug();
    test_encrypt();
    test_invalid();
    test_reset_mid_press();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
